// File: rtl/priority_decoder_pkg.sv
// Shared types and helpers for the priority decoder: FSM states, code word layout, decode functions.
package priority_decoder_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned WORD_W = CODE_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic              none;
    logic [CODE_W-1:0] idx;
  } code_t;

  // A none word decodes to all zeros so the one-hot output never carries a stale bit.
  function automatic logic [OUT_W-1:0] onehot(input code_t c);
    return c.none ? '0 : (OUT_W'(1) << c.idx);
  endfunction

  // Bits 0..idx set; ~(FE << idx) avoids the 9-bit overflow of (2 << idx) - 1.
  function automatic logic [OUT_W-1:0] thermo(input code_t c);
    return c.none ? '0 : ~(OUT_W'(8'hFE) << c.idx);
  endfunction

endpackage

// File: rtl/prio_code_fifo.sv
// Code-word FIFO for the priority decoder: power-of-two depth, combinational head, occupancy level.
module prio_code_fifo
  import priority_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WORD_W-1:0]       wdata,
  output logic [WORD_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (level != LVL_W'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: level gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/priority_decoder.sv
// Buffers encoded priority words and drives each one-hot decode for hold_cycles cycles.
// Define PRIO_DEC_THERMO_EN to add the registered thermometer output thermo_out.
module priority_decoder
  import priority_decoder_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned HOLD_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CODE_W-1:0]       in_idx,
  input  logic                    in_none,
  input  logic [HOLD_W-1:0]       hold_cycles,
  output logic [OUT_W-1:0]        out_onehot,
  output logic                    out_active,
  output logic                    out_none,
  output logic [$clog2(DEPTH):0]  fifo_level
`ifdef PRIO_DEC_THERMO_EN
  ,
  output logic [OUT_W-1:0]        thermo_out
`endif
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_d;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_d;
  logic              push;
  logic              pop;
  logic              load;
  code_t             in_word;
  code_t             head;
  logic [OUT_W-1:0]  onehot_d;
  logic              none_d;
  logic              active_d;
`ifdef PRIO_DEC_THERMO_EN
  logic [OUT_W-1:0]  thermo_d;
`endif

  // No pop bypass: a full FIFO refuses a word even on a pop edge.
  assign in_ready = (fifo_level != LVL_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign in_word  = code_t'({in_none, in_idx});

  prio_code_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_word),
    .rdata (head),
    .level (fifo_level)
  );

  // Next state, counter and output values; a load pops the head and restarts the hold.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    load     = 1'b0;
    pop      = 1'b0;
    onehot_d = out_onehot;
    none_d   = out_none;
    active_d = out_active;
`ifdef PRIO_DEC_THERMO_EN
    thermo_d = thermo_out;
`endif
    case (state)
      IDLE: begin
        if (fifo_level != '0) load = 1'b1;
      end
      DRIVE: begin
        if (cnt == HOLD_W'(1)) begin
          if (fifo_level != '0) begin
            load = 1'b1;
          end else begin
            state_d  = IDLE;
            cnt_d    = '0;
            onehot_d = '0;
            none_d   = 1'b0;
            active_d = 1'b0;
`ifdef PRIO_DEC_THERMO_EN
            thermo_d = '0;
`endif
          end
        end else begin
          cnt_d = cnt - HOLD_W'(1);
        end
      end
    endcase
    if (load) begin
      pop      = 1'b1;
      state_d  = DRIVE;
      cnt_d    = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
      onehot_d = onehot(head);
      none_d   = head.none;
      active_d = 1'b1;
`ifdef PRIO_DEC_THERMO_EN
      thermo_d = thermo(head);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_onehot <= '0;
      out_none   <= 1'b0;
      out_active <= 1'b0;
`ifdef PRIO_DEC_THERMO_EN
      thermo_out <= '0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      out_onehot <= onehot_d;
      out_none   <= none_d;
      out_active <= active_d;
`ifdef PRIO_DEC_THERMO_EN
      thermo_out <= thermo_d;
`endif
    end
  end

endmodule

// File: tb/tb_priority_decoder.sv
// Directed self-checking bench for priority_decoder (DEPTH=4, HOLD_W=4); covers thermo_out when PRIO_DEC_THERMO_EN is defined.
module tb_priority_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic       in_none;
  logic [3:0] hold_cycles;
  logic [7:0] out_onehot;
  logic       out_active;
  logic       out_none;
  logic [2:0] fifo_level;
`ifdef PRIO_DEC_THERMO_EN
  logic [7:0] thermo_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priority_decoder #(
    .DEPTH  (4),
    .HOLD_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_idx      (in_idx),
    .in_none     (in_none),
    .hold_cycles (hold_cycles),
    .out_onehot  (out_onehot),
    .out_active  (out_active),
    .out_none    (out_none),
    .fifo_level  (fifo_level)
`ifdef PRIO_DEC_THERMO_EN
    ,
    .thermo_out  (thermo_out)
`endif
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [2:0] idx, input logic none);
    in_valid = 1'b1;
    in_idx   = idx;
    in_none  = none;
    tick();
    in_valid = 1'b0;
    in_none  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_idx = 3'd0; in_none = 1'b0; hold_cycles = 4'd0;
    tick(); tick();
    checks++; if (out_onehot !== 8'h00) begin errors++; $display("FAIL reset_onehot got %h expected %h", out_onehot, 8'h00); end
    checks++; if (out_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b expected 0", out_active); end
    checks++; if (out_none !== 1'b0) begin errors++; $display("FAIL reset_none got %b expected 0", out_none); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d expected 0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    hold_cycles = 4'd3;
    push_word(3'd5, 1'b0);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level got %0d expected 1", fifo_level); end
    checks++; if (out_active !== 1'b0) begin errors++; $display("FAIL single_latency_active got %b expected 0", out_active); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_onehot !== 8'h20 || out_active !== 1'b1) begin errors++; $display("FAIL single_drive%0d got %h/%b expected 20/1", i, out_onehot, out_active); end
    end
    tick();
    checks++; if (out_onehot !== 8'h00 || out_active !== 1'b0) begin errors++; $display("FAIL single_end got %h/%b expected 00/0", out_onehot, out_active); end
  endtask

  task automatic test_back_to_back();
    hold_cycles = 4'd1;
    in_valid = 1'b1; in_idx = 3'd0; in_none = 1'b0;
    tick();
    checks++; if (fifo_level !== 3'd1 || out_active !== 1'b0) begin errors++; $display("FAIL b2b_first got lvl %0d act %b expected 1/0", fifo_level, out_active); end
    in_idx = 3'd7;
    tick();
    checks++; if (out_onehot !== 8'h01) begin errors++; $display("FAIL b2b_idx0 got %h expected 01", out_onehot); end
    in_idx = 3'd0; in_none = 1'b1;
    tick();
    in_valid = 1'b0; in_none = 1'b0;
    checks++; if (out_onehot !== 8'h80 || out_none !== 1'b0) begin errors++; $display("FAIL b2b_idx7 got %h/%b expected 80/0", out_onehot, out_none); end
    tick();
    checks++; if (out_onehot !== 8'h00 || out_none !== 1'b1 || out_active !== 1'b1) begin errors++; $display("FAIL b2b_none got %h/%b/%b expected 00/1/1", out_onehot, out_none, out_active); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL b2b_level got %0d expected 0", fifo_level); end
    tick();
    checks++; if (out_active !== 1'b0 || out_none !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b/%b expected 0/0", out_active, out_none); end
  endtask

  task automatic test_hold_zero();
    hold_cycles = 4'd0;
    push_word(3'd2, 1'b0);
    tick();
    checks++; if (out_onehot !== 8'h04 || out_active !== 1'b1) begin errors++; $display("FAIL hold0_drive got %h/%b expected 04/1", out_onehot, out_active); end
    tick();
    checks++; if (out_onehot !== 8'h00 || out_active !== 1'b0) begin errors++; $display("FAIL hold0_end got %h/%b expected 00/0", out_onehot, out_active); end
  endtask

  task automatic test_full();
    logic [7:0] exp_seq [4];
    logic [7:0] prev;
    int waited;
    int n;
    exp_seq[0] = 8'h08; exp_seq[1] = 8'h10; exp_seq[2] = 8'h20; exp_seq[3] = 8'h40;
    hold_cycles = 4'd15;
    for (int w = 1; w <= 5; w++) push_word(3'(w), 1'b0);
    checks++; if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_level got lvl %0d rdy %b expected 4/0", fifo_level, in_ready); end
    checks++; if (out_onehot !== 8'h02) begin errors++; $display("FAIL full_first got %h expected 02", out_onehot); end
    in_valid = 1'b1; in_idx = 3'd6; in_none = 1'b0;
    waited = 0;
    while (!in_ready && waited < 40) begin tick(); waited++; end
    checks++; if (waited !== 12) begin errors++; $display("FAIL full_wait got %0d expected 12", waited); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_onehot !== 8'h04 || fifo_level !== 3'd4) begin errors++; $display("FAIL full_after_push got %h lvl %0d expected 04/4", out_onehot, fifo_level); end
    prev = 8'h04;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (out_onehot === prev && n < 40) begin tick(); n++; end
      checks++; if (out_onehot !== exp_seq[k]) begin errors++; $display("FAIL full_order%0d got %h expected %h", k, out_onehot, exp_seq[k]); end
      n = 0;
      while (out_onehot === exp_seq[k] && n < 40) begin tick(); n++; end
      checks++; if (n !== 15) begin errors++; $display("FAIL full_hold%0d got %0d expected 15", k, n); end
      prev = exp_seq[k];
    end
    checks++; if (out_active !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL full_drain got act %b lvl %0d expected 0/0", out_active, fifo_level); end
  endtask

  task automatic test_reset_mid();
    int seen;
    hold_cycles = 4'd15;
    push_word(3'd1, 1'b0);
    push_word(3'd2, 1'b0);
    push_word(3'd3, 1'b0);
    tick(); tick();
    checks++; if (fifo_level !== 3'd2 || out_onehot !== 8'h02) begin errors++; $display("FAIL rstmid_pre got lvl %0d oh %h expected 2/02", fifo_level, out_onehot); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_onehot !== 8'h00 || out_active !== 1'b0 || fifo_level !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async got oh %h act %b lvl %0d rdy %b expected 00/0/0/1", out_onehot, out_active, fifo_level, in_ready); end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (out_active !== 1'b0 || out_onehot !== 8'h00) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_stale got %0d active cycles expected 0", seen); end
  endtask

`ifdef PRIO_DEC_THERMO_EN
  task automatic test_thermo();
    hold_cycles = 4'd1;
    push_word(3'd3, 1'b0);
    tick();
    checks++; if (thermo_out !== 8'h0F || out_onehot !== 8'h08) begin errors++; $display("FAIL thermo got %h/%h expected 0F/08", thermo_out, out_onehot); end
    tick();
    checks++; if (thermo_out !== 8'h00) begin errors++; $display("FAIL thermo_idle got %h expected 00", thermo_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_zero();
    test_full();
    test_reset_mid();
`ifdef PRIO_DEC_THERMO_EN
    test_thermo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of input FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter HOLD_W, default 4, giving the width of the hold-count input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an encoded code word is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a code word this cycle.
REQ-007 SHALL have port in_idx, input, 3 bits: the encoded index of the highest-priority set bit.
REQ-008 SHALL have port in_none, input, 1 bit: the encoder saw no set bit; in_idx is ignored.
REQ-009 SHALL have port hold_cycles, input, HOLD_W bits: the number of cycles each decoded word is driven.
REQ-010 SHALL have port out_onehot, output, 8 bits: the registered one-hot decode of the current word.
REQ-011 SHALL have port out_active, output, 1 bit: a word is being driven (state DRIVE).
REQ-012 SHALL have port out_none, output, 1 bit: the current word is a "none" word.
REQ-013 SHALL have port fifo_level, output, $clog2(DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-014 SHALL accept a word on any rising edge where in_valid && in_ready, writing {in_none, in_idx} to the FIFO tail.
REQ-015 SHALL drive in_ready = (fifo_level != DEPTH), combinational from registered state with no pop bypass; a full FIFO blocks acceptance even in a pop cycle.
REQ-016 SHALL implement a two-state FSM with states IDLE and DRIVE.
REQ-017 In IDLE with the FIFO non-empty, SHALL pop the head, load the counter, and enter DRIVE on the next edge.
REQ-018 In IDLE with the FIFO empty, SHALL remain in IDLE.
REQ-019 On each pop, SHALL load the counter from hold_cycles sampled at that edge, with value 0 treated as 1.
REQ-020 In DRIVE, SHALL decrement the counter each cycle.
REQ-021 In DRIVE with counter == 1 and the FIFO non-empty, SHALL pop and reload back-to-back with no idle gap.
REQ-022 In DRIVE with counter == 1 and the FIFO empty, SHALL return to IDLE.
REQ-023 SHALL register outputs at the pop edge: out_onehot = 1 << idx, or 8'h00 for a none word; out_none = popped none flag; out_active = 1.
REQ-024 In IDLE, SHALL hold out_onehot = 0, out_none = 0 and out_active = 0.
REQ-025 SHALL have a latency of one cycle: a word accepted at edge N into an empty FIFO while IDLE appears on the outputs after edge N+1.
REQ-026 SHALL apply a push and a pop on the same edge together, leaving fifo_level unchanged.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH.
REQ-028 SHALL guarantee that out_onehot never has more than one bit set.

Reset
REQ-029 While rst is high, SHALL asynchronously set the FSM to IDLE, the counter to 0, pointers to 0, fifo_level to 0, and all outputs to 0 (in_ready = 1 after reset).
REQ-030 SHALL discard FIFO contents and any in-flight word when reset is asserted mid-DRIVE.
REQ-031 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-032 With PRIO_DEC_THERMO_EN defined, SHALL add output thermo_out, 8 bits, registered with out_onehot, equal to (2 << idx) - 1 (bits 0..idx set), 0 for none words and in IDLE.
REQ-033 Without PRIO_DEC_THERMO_EN, SHALL omit the thermo_out port and its logic entirely.

Structure
REQ-034 SHALL place FSM state typedef (IDLE, DRIVE), CODE_W = 3 and OUT_W = 8 in package priority_decoder_pkg.
REQ-035 SHALL implement the FIFO as a sub-module prio_code_fifo (DEPTH, 4-bit data, push/pop/level).

Verification
REQ-036 Reset release, push idx=5, hold=3 -> out_onehot = 8'h20 for exactly 3 cycles starting the cycle after acceptance, then 0 with out_active = 0.
REQ-037 Push idx 0, 7, none back-to-back, hold=1 -> outputs 8'h01, 8'h80, 8'h00 with out_none = 1 on consecutive cycles, no gap.
REQ-038 hold=0, push idx=2 -> out_onehot = 8'h04 for exactly 1 cycle.
REQ-039 hold=15, push 5 words with DEPTH=4 -> in_ready low once level = 4; the 5th word is accepted only after a pop; order is preserved across pointer wrap.
REQ-040 Assert rst mid-DRIVE with 2 words queued -> outputs 0 immediately, fifo_level = 0, no queued word appears after release.
REQ-041 With PRIO_DEC_THERMO_EN, push idx=3 -> thermo_out = 8'h0F alongside out_onehot = 8'h08.
